// File: rtl/alu_mult_seq.sv
// Sequential 32x32 unsigned shift-add multiplier that borrows the shared alu_32
// adder each iteration and builds a 64-bit product over 32 CALC cycles.
module alu_mult_seq #(
  parameter logic [3:0] ADD_SEL  = 4'b0010,
  parameter logic [3:0] IDLE_SEL = 4'b0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product_hi,
  output logic [31:0] product_lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry
);

  localparam int unsigned W      = 32;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     mcand;
  logic [W-1:0]     acc_hi;
  logic [W-1:0]     acc_lo;
  logic [CNT_W-1:0] count;
  logic [2*W-1:0]   step_c;

  // The ALU always sees the live partial-product high word and the multiplicand.
  assign alu_a = acc_hi;
  assign alu_b = mcand;

  // One shift-add step: take the ALU sum (with carry as bit 32) when the
  // current multiplier bit is set, otherwise just shift the accumulator.
  always_comb begin
    step_c = {1'b0, acc_hi, acc_lo[W-1:1]};
    if (acc_lo[0]) begin
      step_c = {alu_carry, alu_out, acc_lo[W-1:1]};
    end
  end

  // Controller FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      alu_sel    <= IDLE_SEL;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= multiplicand;
            acc_hi  <= '0;
            acc_lo  <= multiplier;
            count   <= '0;
            busy    <= 1'b1;
            alu_sel <= ADD_SEL;
            state   <= CALC;
          end
        end
        CALC: begin
          acc_hi <= step_c[2*W-1:W];
          acc_lo <= step_c[W-1:0];
          count  <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            product_hi <= step_c[2*W-1:W];
            product_lo <= step_c[W-1:0];
            done       <= 1'b1;
            alu_sel    <= IDLE_SEL;
            state      <= DONE;
          end
        end
        DONE: begin
          // Start requests are ignored here; the next one is taken in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          alu_sel <= IDLE_SEL;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural alu_32 model and a
// product scoreboard checked on each done pulse.
module tb_alu_mult_seq;

  localparam logic [3:0] ADD_SEL  = 4'b0010;
  localparam logic [3:0] IDLE_SEL = 4'b0000;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry;
  logic [32:0] alu_sum;

  int tests;
  int fails;
  int done_cnt;
  int flag_bad;
  logic done_q;
  logic [63:0] exp_q[$];

  alu_mult_seq #(.ADD_SEL(ADD_SEL), .IDLE_SEL(IDLE_SEL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done),
    .product_hi(product_hi), .product_lo(product_lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  // Behavioural ALU: add on ADD_SEL, bitwise AND otherwise.
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = (alu_sel == ADD_SEL) ? alu_sum[31:0] : (alu_a & alu_b);
  assign alu_carry = (alu_sel == ADD_SEL) ? alu_sum[32] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track done pulses and handshake invariants between clock edges.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b1) flag_bad++;
      if (done_q === 1'b1) flag_bad++;
    end
    done_q <= done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start at the current falling edge; it is accepted at the next rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    if (push) exp_q.push_back(64'(a) * 64'(b));
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  // Wait for done after an accepted start, optionally injecting stray starts
  // at the given cycle offsets; then check the product and the busy drop.
  task automatic finish_op(input string tag, input int p1, input int p2);
    int lat;
    int sel_bad;
    int hold_bad;
    logic [63:0] prev;
    logic [63:0] exp;
    lat = 0;
    sel_bad = 0;
    hold_bad = 0;
    prev = {product_hi, product_lo};
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    if (alu_sel !== ADD_SEL) sel_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c < 32) begin
        if (alu_sel !== ADD_SEL) sel_bad++;
        if ({product_hi, product_lo} !== prev) hold_bad++;
      end else if (alu_sel !== IDLE_SEL) begin
        sel_bad++;
      end
      if (c == p1 || c == p2) begin
        start = 1'b1;
        multiplicand = 32'd2;
        multiplier = 32'd2;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, "_product"}, {product_hi, product_lo}, exp);
    chk({tag, "_alu_sel"}, 64'(sel_bad), 64'd0);
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_fall"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_idle_sel"}, 64'(alu_sel), 64'(IDLE_SEL));
  endtask

  initial begin
    int cnt0;
    tests = 0;
    fails = 0;
    done_cnt = 0;
    flag_bad = 0;
    done_q = 1'b0;
    reset_n = 1'b0;
    start = 1'b0;
    multiplicand = 32'hA5A5A5A5;
    multiplier = 32'h5A5A5A5A;

    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, alu_sel, product_hi[0], product_lo[0]}, {1'b0, 1'b0, IDLE_SEL, 2'b00});
    chk("reset_product", {product_hi, product_lo}, 64'd0);
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 64'(busy), 64'd0);

    start_op(32'd3, 32'd5, 1'b1);
    finish_op("m3x5", 0, 0);

    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    finish_op("mff", 0, 0);

    start_op(32'h80000000, 32'h00000002, 1'b1);
    finish_op("m8x2", 0, 0);

    start_op(32'd0, 32'h12345678, 1'b1);
    finish_op("m0", 0, 0);

    // Stray starts mid-CALC and in DONE must be ignored.
    cnt0 = done_cnt;
    start_op(32'd7, 32'd9, 1'b1);
    finish_op("m7x9", 5, 32);
    repeat (3) @(negedge clk);
    chk("ignored_busy", 64'(busy), 64'd0);
    chk("ignored_one_done", 64'(done_cnt - cnt0), 64'd1);
    chk("ignored_product", {product_hi, product_lo}, 64'd63);

    // Reset in the middle of CALC abandons the operation.
    cnt0 = done_cnt;
    start_op(32'hDEADBEEF, 32'h10, 1'b0);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_cleared", {busy, done, product_hi, product_lo}, 66'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - cnt0), 64'd0);
    start_op(32'd6, 32'd7, 1'b1);
    finish_op("m6x7", 0, 0);

    // Back-to-back: next start in the first IDLE cycle after done.
    start_op(32'd100, 32'd100, 1'b1);
    finish_op("m100", 0, 0);
    start_op(32'h10000, 32'h10000, 1'b1);
    finish_op("m10000", 0, 0);

    chk("handshake_invariants", 64'(flag_bad), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
